// File: rtl/rom_pkg.sv
// Shared types and default widths for the ROM download path.
package rom_pkg;

   localparam int ADDR_W_DEF = 25;
   localparam int MEM_AW_DEF = 20;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_FETCH,
      ST_SEND,
      ST_GAP_WAIT,
      ST_FINISH
   } tx_state_e;

endpackage

// File: rtl/ioctl_download_tx.sv
// Streams a memory region out as ioctl write beats, one byte per beat.
// Define ROM_TX_CHECKSUM_EN to add a 16-bit running byte checksum output.
module ioctl_download_tx
   import rom_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int MEM_AW = MEM_AW_DEF,
   parameter int GAP    = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [MEM_AW-1:0] src_base,
   input  logic [ADDR_W-1:0] dest_base,
   input  logic [MEM_AW:0]   length,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_data,
   output logic              ioctl_download,
   output logic [ADDR_W-1:0] ioctl_addr,
   output logic [7:0]        ioctl_dout,
   output logic              ioctl_wr,
   input  logic              ioctl_wait,
   output logic              busy,
   output logic              done
`ifdef ROM_TX_CHECKSUM_EN
   ,
   output logic [15:0]       checksum
`endif
);

   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   tx_state_e         state_q, state_d;
   logic [MEM_AW-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [MEM_AW:0]   len_q, len_d;
   logic [MEM_AW:0]   offs_q, offs_d;
   logic [MEM_AW:0]   offs_inc;
   logic [GW-1:0]     gap_q, gap_d;
   logic [7:0]        dout_q;
   logic              start_ok;
   logic              accept;

   assign start_ok = (state_q == ST_IDLE) && start;
   // Abort wins over a beat that would otherwise be accepted this cycle.
   assign accept   = (state_q == ST_SEND) && !ioctl_wait && !abort;
   assign offs_inc = offs_q + 1'b1;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dest_d  = dest_q;
      len_d   = len_q;
      offs_d  = offs_q;
      gap_d   = gap_q;
      if (abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  src_d   = src_base;
                  dest_d  = dest_base;
                  len_d   = length;
                  offs_d  = '0;
                  state_d = (length == '0) ? ST_FINISH : ST_READ;
               end
            end
            ST_READ:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_SEND;
            ST_SEND: begin
               if (accept) begin
                  offs_d = offs_inc;
                  gap_d  = '0;
                  if (offs_inc == len_q)
                     state_d = ST_FINISH;
                  else if (GAP > 0)
                     state_d = ST_GAP_WAIT;
                  else
                     state_d = ST_READ;
               end
            end
            ST_GAP_WAIT: begin
               if (32'(gap_q) >= GAP - 1)
                  state_d = ST_READ;
               else
                  gap_d = gap_q + 1'b1;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         src_q   <= '0;
         dest_q  <= '0;
         len_q   <= '0;
         offs_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dest_q  <= dest_d;
         len_q   <= len_d;
         offs_q  <= offs_d;
         gap_q   <= gap_d;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         dout_q <= '0;
      else if (state_q == ST_FETCH)
         dout_q <= mem_data;
   end

   assign mem_rd     = (state_q == ST_READ);
   assign mem_addr   = src_q + offs_q[MEM_AW-1:0];
   assign ioctl_addr = dest_q + ADDR_W'(offs_q);
   assign ioctl_dout = dout_q;
   assign ioctl_wr   = accept;
   assign busy       = (state_q != ST_IDLE);
   assign done       = (state_q == ST_FINISH);

   assign ioctl_download = (state_q == ST_READ)
                        || (state_q == ST_FETCH)
                        || (state_q == ST_SEND)
                        || (state_q == ST_GAP_WAIT);

`ifdef ROM_TX_CHECKSUM_EN
   logic [15:0] cks_q, cks_d;

   always_comb begin
      cks_d = cks_q;
      if (start_ok)
         cks_d = '0;
      else if (accept)
         cks_d = cks_q + {8'h00, dout_q};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cks_q <= '0;
      else
         cks_q <= cks_d;
   end

   assign checksum = cks_q;
`endif

endmodule
